// File: rtl/ram_arbiter.sv
// Three-way SRAM port arbiter (video > CPU > DMA) with a fixed per-access strobe
// sequence, one-cycle acknowledges and a DMA anti-starvation counter.
module ram_arbiter #(
  parameter int ACCESS_CYCLES = 3,
  parameter int STARVE_LIMIT  = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        vReq,
  input  logic [17:0] vA,
  output logic        vAck,
  output logic [7:0]  vQ,
  input  logic        cReq,
  input  logic        cWr,
  input  logic [17:0] cA,
  input  logic [7:0]  cD,
  output logic        cAck,
  output logic [7:0]  cQ,
  input  logic        dReq,
  input  logic        dWr,
  input  logic [17:0] dA,
  input  logic [7:0]  dD,
  output logic        dAck,
  output logic [7:0]  dQ,
  output logic        ramRd,
  output logic        ramWr,
  output logic [17:0] ramA,
  output logic [7:0]  ramD,
  input  logic [7:0]  ramQ,
  output logic        busy
);

  localparam int CW = (ACCESS_CYCLES > 4) ? $clog2(ACCESS_CYCLES) : 2;
  localparam logic [CW-1:0] CNT_LAST = CW'(ACCESS_CYCLES - 1);
  localparam logic [CW-1:0] WR_LAST  = CW'(ACCESS_CYCLES - 2);
  localparam logic [7:0]    LIMIT    = 8'(STARVE_LIMIT);
  localparam logic [1:0]    ID_V     = 2'd0;
  localparam logic [1:0]    ID_C     = 2'd1;
  localparam logic [1:0]    ID_D     = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  state_t          r_state;
  logic [CW-1:0]   r_cnt;
  logic [7:0]      r_starve;
  logic [1:0]      r_id;
  logic            r_wr;
  logic            r_v_ack, r_c_ack, r_d_ack;
  logic [7:0]      r_v_q, r_c_q, r_d_q;
  logic            r_ram_rd, r_ram_wr;
  logic [17:0]     r_ram_a;
  logic [7:0]      r_ram_d;
  logic            r_busy;

  logic            w_force_dma;
  logic            w_grant_v, w_grant_c, w_grant_d, w_any;
  logic [1:0]      w_win_id;
  logic            w_win_wr;
  logic [17:0]     w_win_a;
  logic [7:0]      w_win_d;
  logic [7:0]      w_starve_nxt;
  logic [CW-1:0]   w_cnt_nxt;

  // Winner selection; video never carries write data, so ramD keeps its value for it.
  always_comb begin
    w_force_dma = dReq && (r_starve == LIMIT);
    w_grant_v   = 1'b0;
    w_grant_c   = 1'b0;
    w_grant_d   = 1'b0;
    w_win_id    = ID_V;
    w_win_wr    = 1'b0;
    w_win_a     = r_ram_a;
    w_win_d     = r_ram_d;
    if (vReq) begin
      w_grant_v = 1'b1;
      w_win_a   = vA;
    end else if (dReq && (!cReq || w_force_dma)) begin
      w_grant_d = 1'b1;
      w_win_id  = ID_D;
      w_win_wr  = dWr;
      w_win_a   = dA;
      w_win_d   = dD;
    end else if (cReq) begin
      w_grant_c = 1'b1;
      w_win_id  = ID_C;
      w_win_wr  = cWr;
      w_win_a   = cA;
      w_win_d   = cD;
    end else begin
      w_win_id  = ID_V;
    end
    w_any = w_grant_v | w_grant_c | w_grant_d;
  end

  // Starvation counter update applied on each IDLE sample.
  always_comb begin
    w_starve_nxt = r_starve;
    if (!dReq) begin
      w_starve_nxt = 8'd0;
    end else if (w_grant_d) begin
      w_starve_nxt = 8'd0;
    end else if (w_grant_c && (r_starve < LIMIT)) begin
      w_starve_nxt = r_starve + 8'd1;
    end else begin
      w_starve_nxt = r_starve;
    end
    w_cnt_nxt = r_cnt + {{(CW-1){1'b0}}, 1'b1};
  end

  // Arbiter FSM with all outputs registered.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_starve <= 8'd0;
      r_id     <= ID_V;
      r_wr     <= 1'b0;
      r_v_ack  <= 1'b0;
      r_c_ack  <= 1'b0;
      r_d_ack  <= 1'b0;
      r_v_q    <= 8'd0;
      r_c_q    <= 8'd0;
      r_d_q    <= 8'd0;
      r_ram_rd <= 1'b0;
      r_ram_wr <= 1'b0;
      r_ram_a  <= 18'd0;
      r_ram_d  <= 8'd0;
      r_busy   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_starve <= w_starve_nxt;
          if (w_any) begin
            r_state  <= S_ACCESS;
            r_cnt    <= '0;
            r_id     <= w_win_id;
            r_wr     <= w_win_wr;
            r_ram_a  <= w_win_a;
            r_ram_d  <= w_win_d;
            r_ram_rd <= !w_win_wr;
            r_ram_wr <= 1'b0;
            r_busy   <= 1'b1;
          end
        end
        S_ACCESS: begin
          r_cnt <= w_cnt_nxt;
          if (r_cnt == CNT_LAST) begin
            r_state  <= S_DONE;
            r_ram_rd <= 1'b0;
            r_ram_wr <= 1'b0;
            r_v_ack  <= (r_id == ID_V);
            r_c_ack  <= (r_id == ID_C);
            r_d_ack  <= (r_id == ID_D);
            if (!r_wr && (r_id == ID_V)) r_v_q <= ramQ;
            if (!r_wr && (r_id == ID_C)) r_c_q <= ramQ;
            if (!r_wr && (r_id == ID_D)) r_d_q <= ramQ;
          end else begin
            // Write strobe excludes the first and last cycle for setup/hold.
            r_ram_wr <= r_wr && (w_cnt_nxt <= WR_LAST);
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_v_ack <= 1'b0;
          r_c_ack <= 1'b0;
          r_d_ack <= 1'b0;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state  <= S_IDLE;
          r_ram_rd <= 1'b0;
          r_ram_wr <= 1'b0;
          r_busy   <= 1'b0;
        end
      endcase
    end
  end

  assign vAck  = r_v_ack;
  assign cAck  = r_c_ack;
  assign dAck  = r_d_ack;
  assign vQ    = r_v_q;
  assign cQ    = r_c_q;
  assign dQ    = r_d_q;
  assign ramRd = r_ram_rd;
  assign ramWr = r_ram_wr;
  assign ramA  = r_ram_a;
  assign ramD  = r_ram_d;
  assign busy  = r_busy;

endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Arbitrates the single external 8-bit SRAM port (18-bit address) between three requesters: video fetch, the Z80 CPU/memory mapper and a low-priority DMA/loader port (uSD image loader). Sits between the memory block and the board SRAM pins on the 56 MHz `clock` domain. Grants one access at a time with a fixed, cycle-exact SRAM strobe sequence, returns read data with a one-cycle acknowledge, and prevents DMA starvation under continuous CPU traffic.

## Interface
Parameters:
- `ACCESS_CYCLES`, 3: clock cycles the SRAM address/data are driven per access; minimum 3.
- `STARVE_LIMIT`, 8: consecutive CPU grants while DMA is pending before DMA is forced ahead of the CPU; range 1–255.

Ports:
- `clock`  in  1  system clock, 56 MHz; all logic on posedge.
- `reset`  in  1  asynchronous, active-low reset.
- `vReq`  in  1  video request, level.
- `vA`  in  18  video address. Video is read-only.
- `vAck`  out  1  one-cycle acknowledge.
- `vQ`  out  8  video read data, valid while `vAck` is high; held until the next video ack.
- `cReq`  in  1  CPU request, level.
- `cWr`  in  1  CPU access type: 1 = write, 0 = read.
- `cA`  in  18  CPU address.
- `cD`  in  8  CPU write data.
- `cAck`  out  1  one-cycle acknowledge.
- `cQ`  out  8  CPU read data, same rules as `vQ`.
- `dReq`, `dWr`, `dA`, `dD`, `dAck`, `dQ`: DMA port, same widths and meaning as the CPU port.
- `ramRd`  out  1  SRAM read strobe, active-high.
- `ramWr`  out  1  SRAM write strobe, active-high.
- `ramA`  out  18  SRAM address.
- `ramD`  out  8  SRAM write data.
- `ramQ`  in  8  SRAM read data.
- `busy`  out  1  high in ACCESS and DONE states.

## Operation
- FSM states: IDLE, ACCESS, DONE.
- IDLE: at each posedge, sample `vReq`, `cReq` and `dReq`.
  - No request: remain in IDLE.
  - Any request: latch the winner's id, address, data and type into registers, load `cnt` = 0, go to ACCESS.
- Priority:
  - Video always wins.
  - Otherwise the CPU beats DMA, except when `dReq` = 1 and `starve` = `STARVE_LIMIT`; then DMA wins.
- Starvation counter `starve` (8-bit):
  - +1 on each CPU grant made while `dReq` = 1, saturating at `STARVE_LIMIT`.
  - Cleared to 0 on a DMA grant, and on any IDLE sample with `dReq` = 0.
  - Video grants leave it unchanged.
- ACCESS: lasts exactly `ACCESS_CYCLES` cycles; `cnt` runs 0 … `ACCESS_CYCLES`-1.
  - `ramA` and `ramD` hold the latched values for the whole access.
  - Read: `ramRd` = 1 for all cycles of the access.
  - Write: `ramWr` = 1 only for `cnt` = 1 … `ACCESS_CYCLES`-2, giving one cycle of address setup and one cycle of hold.
  - On the posedge that ends `cnt` = `ACCESS_CYCLES`-1: for reads, `ramQ` is registered into the winner's Q output; go to DONE.
- DONE: the winner's ack is high for this single cycle, then go to IDLE. Strobes are low.
- Requesters must drop `req` at the posedge following their ack, unless they want a further access. A req still high in the following IDLE cycle is treated as a new request.
- Request inputs must be stable from `req` rise until ack. Changes to inputs of a requester that is not granted are ignored.
- Between accesses, `ramA`/`ramD` keep their last values and strobes are 0.

## Timing
- Grant decision made at posedge P, in IDLE.
- Access cycles: P+1 … P+`ACCESS_CYCLES`.
- Ack high in cycle P+`ACCESS_CYCLES`+1.
- Next possible grant: posedge at the end of cycle P+`ACCESS_CYCLES`+2.
- Throughput with default parameters: one access per 5 clocks.
- Worst-case wait for the CPU behind video: one in-flight access plus one video access = 10 clocks.
- All outputs are registered; no combinational path from any req to any output.
- Reset (asynchronous, `reset` = 0):
  - FSM forced to IDLE; `cnt` = 0; `starve` = 0.
  - `ramRd` = `ramWr` = 0, `ramA` = 0, `ramD` = 0.
  - All acks = 0, all Q = 0, `busy` = 0.
  - Reset asserted mid-access aborts the access immediately; no ack is issued.
- After `reset` releases, the first grant can occur at the first posedge.

## Test plan
- CPU read: `cReq`=1, `cWr`=0, `cA`=18'h04000, SRAM model returns 8'h5A.
  - Required: `ramRd` high for exactly 3 clocks with `ramA`=18'h04000.
  - Required: `cAck` high one clock later with `cQ`=8'h5A.
- DMA write: `dA`=18'h3FFFF, `dD`=8'hC3.
  - Required: `ramWr` high only in the second access cycle; `ramA` and `ramD` stable for all 3 cycles; SRAM model holds 8'hC3 at 18'h3FFFF.
  - Required: `dAck` in cycle 4 after grant.
- Simultaneous `vReq`, `cReq` and `dReq` rising in the same cycle.
  - Required: acks in order video, CPU, DMA, 5 clocks apart.
  - Required: `busy` never low between them, except the single IDLE cycle per access.
- Starvation, `STARVE_LIMIT`=8: CPU re-requests immediately after every ack while `dReq` is held at 1.
  - Required: 8 CPU grants, then a DMA grant, then CPU grants resume.
  - Required: `starve` returns to 0 after the DMA grant.
- Async reset pulse during cycle 2 of a CPU write.
  - Required: `ramWr` drops without waiting for a clock edge; `cAck` is never asserted; all outputs read 0.
  - Required: after release with `cReq` still 1, a fresh access starts at the first posedge.
- Held request: `cReq` kept at 1 across its ack.
  - Required: a second CPU access is granted at the IDLE cycle that follows.
